// File: rtl/l2_cache.sv
// Direct-mapped, write-back, write-allocate L2 cache between the L1 line port and main memory.
// Single-outstanding memory handshake; every miss re-evaluates as a hit in IDLE once the fill completes.
module l2_cache #(
   parameter int INDEX_W = 4
) (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         L2_read,
   input  logic         L2_write,
   input  logic [29:0]  L2_addr,
   input  logic [31:0]  L2_wdata,
   output logic [127:0] L2_rdata,
   output logic         L2_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);
   localparam int TAG_W = 28 - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, RESPOND, WRITEBACK, ALLOCATE} state_t;
   state_t state, state_nxt;

   logic [LINES-1:0] valid_q, dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [127:0]     data_q [LINES];

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   req_tag;
   logic               req, hit;
   logic [127:0]       cur_line, wr_line;
   logic               hit_en, wb_done, fill_done;

   assign idx      = L2_addr[INDEX_W+1:2];
   assign req_tag  = L2_addr[29:INDEX_W+2];
   assign req      = L2_read | L2_write;
   assign cur_line = data_q[idx];
   assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

   // Merged line for a write hit; written to both the array and L2_rdata.
   always_comb begin
      wr_line = cur_line;
      wr_line[{L2_addr[1:0], 5'b00000} +: 32] = L2_wdata;
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) state <= IDLE;
      else               state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      L2_ready  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      hit_en    = 1'b0;
      wb_done   = 1'b0;
      fill_done = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  hit_en    = 1'b1;
                  state_nxt = RESPOND;
               end else if (dirty_q[idx]) begin
                  state_nxt = WRITEBACK;
               end else begin
                  state_nxt = ALLOCATE;
               end
            end
         end
         RESPOND: begin
            L2_ready  = 1'b1;
            state_nxt = IDLE;
         end
         WRITEBACK: begin
            mem_write = 1'b1;
            mem_addr  = {tag_q[idx], idx};
            mem_wdata = cur_line;
            if (mem_ready) begin
               wb_done   = 1'b1;
               state_nxt = ALLOCATE;
            end
         end
         ALLOCATE: begin
            mem_read = 1'b1;
            mem_addr = L2_addr[29:2];
            if (mem_ready) begin
               fill_done = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         valid_q  <= '0;
         dirty_q  <= '0;
         L2_rdata <= '0;
      end else begin
         if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
         end else if (wb_done) begin
            dirty_q[idx] <= 1'b0;
         end else if (hit_en && L2_write) begin
            dirty_q[idx] <= 1'b1;
         end
         if (hit_en) L2_rdata <= L2_write ? wr_line : cur_line;
      end
   end

   // Tags and data carry no reset; valid bits qualify them.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_q[idx] <= mem_rdata;
         tag_q[idx]  <= req_tag;
      end else if (hit_en && L2_write) begin
         data_q[idx] <= wr_line;
      end
   end
endmodule

// File: tb/tb_l2_cache.sv
// Directed bench for l2_cache: a latency-3 memory responder plus hand-computed expected lines.
module tb_l2_cache;
   localparam int MLAT = 3;
   localparam logic [127:0] LINE1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

   logic         clk = 1'b0;
   logic         proc_reset_n;
   logic         L2_read, L2_write;
   logic [29:0]  L2_addr;
   logic [31:0]  L2_wdata;
   logic [127:0] L2_rdata;
   logic         L2_ready;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_ready;

   l2_cache #(.INDEX_W(4)) dut (
      .clk(clk), .proc_reset_n(proc_reset_n),
      .L2_read(L2_read), .L2_write(L2_write), .L2_addr(L2_addr), .L2_wdata(L2_wdata),
      .L2_rdata(L2_rdata), .L2_ready(L2_ready),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int rd_n = 0, wb_n = 0, seq = 0, rd_seq = 0, wb_seq = 0, cnt = 0;
   logic [27:0]  rd_addr, wb_addr;
   logic [127:0] wb_data;
   logic [127:0] wmem [logic [27:0]];

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] line_for(input logic [27:0] a);
      if (wmem.exists(a)) return wmem[a];
      if (a == 28'h10) return LINE1;
      return {4{4'hE, a}};
   endfunction

   // Memory: mem_ready on the MLAT-th cycle a request is held.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
            cnt = 0;
         end
         if (mem_read || mem_write) begin
            cnt++;
            if (cnt == MLAT) begin
               mem_ready = 1'b1;
               seq++;
               if (mem_write) begin
                  wb_n++; wb_addr = mem_addr; wb_data = mem_wdata; wb_seq = seq;
                  wmem[mem_addr] = mem_wdata;
               end else begin
                  rd_n++; rd_addr = mem_addr; rd_seq = seq;
                  mem_rdata = line_for(mem_addr);
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Latency counts the request's first cycle as 1; ready is seen #1 after its posedge.
   task automatic do_req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d,
                         input bit hold, output int lat, output logic [127:0] line);
      int n;
      n = 0;
      @(negedge clk);
      L2_read = rd; L2_write = wr; L2_addr = a; L2_wdata = d;
      do begin
         @(posedge clk); #1; n++;
      end while (!L2_ready && n < 100);
      lat  = L2_ready ? n + 1 : -1;
      line = L2_rdata;
      if (hold) begin
         @(posedge clk); #1;
         chk("held_gap", {127'b0, L2_ready}, 128'd0);
         @(posedge clk); #1;
         chk("held_pulse2", {127'b0, L2_ready}, 128'd1);
         line = L2_rdata;
      end
      L2_read = 1'b0; L2_write = 1'b0;
      @(posedge clk); #1;
   endtask

   int lat, r0, w0, n;
   logic [127:0] line, dirty_line, held_line;

   initial begin
      proc_reset_n = 1'b0;
      L2_read = 1'b0; L2_write = 1'b0; L2_addr = '0; L2_wdata = '0;
      #2;
      chk("rst_ready", {127'b0, L2_ready}, 128'd0);
      chk("rst_rdata", L2_rdata, 128'd0);
      chk("rst_mem_read", {127'b0, mem_read}, 128'd0);
      chk("rst_mem_write", {127'b0, mem_write}, 128'd0);
      chk("rst_mem_addr", {100'b0, mem_addr}, 128'd0);
      chk("rst_mem_wdata", mem_wdata, 128'd0);
      @(negedge clk); @(negedge clk);
      proc_reset_n = 1'b1;

      // Cold read
      do_req(1'b1, 1'b0, 30'h40, 32'h0, 1'b0, lat, line);
      chk("cold_lat", lat, 6);
      chk("cold_line", line, LINE1);
      chk("cold_rd_n", rd_n, 1);
      chk("cold_rd_addr", {100'b0, rd_addr}, 128'h10);
      chk("cold_wb_n", wb_n, 0);

      // Read hit
      do_req(1'b1, 1'b0, 30'h40, 32'h0, 1'b0, lat, line);
      chk("rhit_lat", lat, 2);
      chk("rhit_line", line, LINE1);
      chk("rhit_rd_n", rd_n, 1);

      // Write hit to word 2
      dirty_line = 128'hDDDDDDDD_12345678_BBBBBBBB_AAAAAAAA;
      do_req(1'b0, 1'b1, 30'h42, 32'h1234_5678, 1'b0, lat, line);
      chk("whit_lat", lat, 2);
      chk("whit_line", line, dirty_line);
      chk("whit_mem", rd_n + wb_n, 1);

      // Dirty eviction: same index 0, new tag
      do_req(1'b1, 1'b0, 30'h440, 32'h0, 1'b0, lat, line);
      chk("ev_lat", lat, 9);
      chk("ev_wb_n", wb_n, 1);
      chk("ev_wb_addr", {100'b0, wb_addr}, 128'h10);
      chk("ev_wb_data", wb_data, dirty_line);
      chk("ev_rd_addr", {100'b0, rd_addr}, 128'h110);
      chk("ev_order", {127'b0, wb_seq < rd_seq}, 128'd1);
      chk("ev_line", line, {4{32'hE000_0110}});

      // Held write: second pulse, same contents, no memory traffic
      held_line = {32'hE000_0110, 32'hE000_0110, 32'hCAFE_F00D, 32'hE000_0110};
      r0 = rd_n; w0 = wb_n;
      do_req(1'b0, 1'b1, 30'h441, 32'hCAFE_F00D, 1'b1, lat, line);
      chk("held_lat", lat, 2);
      chk("held_line", line, held_line);
      do_req(1'b1, 1'b0, 30'h440, 32'h0, 1'b0, lat, line);
      chk("held_reread_lat", lat, 2);
      chk("held_reread_line", line, held_line);
      chk("held_mem", (rd_n - r0) + (wb_n - w0), 0);

      // Reset during ALLOCATE
      @(negedge clk);
      L2_read = 1'b1; L2_addr = 30'h84;
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!mem_read && n < 20);
      chk("ra_mem_read_seen", {127'b0, mem_read}, 128'd1);
      #1 proc_reset_n = 1'b0;
      #1;
      chk("ra_mem_read_drop", {127'b0, mem_read}, 128'd0);
      chk("ra_rdata", L2_rdata, 128'd0);
      L2_read = 1'b0;
      @(negedge clk);
      proc_reset_n = 1'b1;
      r0 = rd_n;
      do_req(1'b1, 1'b0, 30'h84, 32'h0, 1'b0, lat, line);
      chk("ra_remiss_lat", lat, 6);
      chk("ra_remiss_rd_n", rd_n - r0, 1);
      chk("ra_remiss_line", line, {4{32'hE000_0021}});

      // Reset dropped the dirty line: clean miss, no write-back
      w0 = wb_n;
      do_req(1'b1, 1'b0, 30'h440, 32'h0, 1'b0, lat, line);
      chk("ra_clean_lat", lat, 6);
      chk("ra_clean_wb", wb_n - w0, 0);
      chk("ra_clean_line", line, {4{32'hE000_0110}});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
